// File: rtl/lcd_pkg.sv
`default_nettype none
// lcd_pkg: shared state encoding, default HD44780 timing counts and command codes.
// LCD_INIT_SEQ_EN adds the power-on init states and the init-sequence ROM.
package lcd_pkg;

    localparam int CNT_W = 20;

    localparam int DEF_SETUP_CYC        = 2;
    localparam int DEF_E_HIGH_CYC       = 12;
    localparam int DEF_NIB_GAP_CYC      = 50;
    localparam int DEF_CHAR_WAIT_CYC    = 2000;
    localparam int DEF_CLEAR_WAIT_CYC   = 82000;
    localparam int DEF_POWERON_WAIT_CYC = 750000;

    // Waits after the first two 0x3 wake-up nibbles of the 4-bit init handshake
    localparam int INIT_WAIT_LONG_CYC  = 205000;
    localparam int INIT_WAIT_SHORT_CYC = 5000;

    localparam logic [7:0] CMD_CLEAR     = 8'h01;
    localparam logic [7:0] CMD_HOME      = 8'h02;
    localparam logic [7:0] CMD_FUNC_4BIT = 8'h28;
    localparam logic [7:0] CMD_ENTRY     = 8'h06;
    localparam logic [7:0] CMD_DISP_ON   = 8'h0C;

    typedef enum logic [3:0] {
        RESET_WAIT = 4'd0,
        IDLE       = 4'd1,
        SETUP      = 4'd2,
        PULSE      = 4'd3,
        GAP        = 4'd4,
        EXEC_WAIT  = 4'd5
`ifdef LCD_INIT_SEQ_EN
        ,
        INIT_WAIT  = 4'd6,
        INIT_NIB   = 4'd7
`endif
    } state_t;

    typedef enum logic [1:0] {
        WAIT_CHAR  = 2'd0,
        WAIT_CLEAR = 2'd1,
        WAIT_LONG  = 2'd2,
        WAIT_SHORT = 2'd3
    } wait_sel_t;

    typedef struct packed {
        logic       is_nibble;
        logic [7:0] cmd;
        wait_sel_t  wait_sel;
    } init_entry_t;

    function automatic wait_sel_t byte_wait_sel(input logic rs, input logic [7:0] cmd);
        byte_wait_sel = (!rs && (cmd == CMD_CLEAR || cmd == CMD_HOME)) ? WAIT_CLEAR : WAIT_CHAR;
    endfunction

`ifdef LCD_INIT_SEQ_EN
    // Nibble entries send only cmd[7:4]
    function automatic init_entry_t init_rom(input logic [2:0] step);
        init_rom = '0;
        case (step)
            3'd0: init_rom = '{1'b1, 8'h30,         WAIT_LONG};
            3'd1: init_rom = '{1'b1, 8'h30,         WAIT_SHORT};
            3'd2: init_rom = '{1'b1, 8'h30,         WAIT_CHAR};
            3'd3: init_rom = '{1'b1, 8'h20,         WAIT_CHAR};
            3'd4: init_rom = '{1'b0, CMD_FUNC_4BIT, WAIT_CHAR};
            3'd5: init_rom = '{1'b0, CMD_ENTRY,     WAIT_CHAR};
            3'd6: init_rom = '{1'b0, CMD_DISP_ON,   WAIT_CHAR};
            3'd7: init_rom = '{1'b0, CMD_CLEAR,     WAIT_CLEAR};
        endcase
    endfunction
`endif

endpackage : lcd_pkg
`default_nettype wire

// File: rtl/lcd_delay_counter.sv
`default_nettype none
// lcd_delay_counter: loadable down-counter that parks at zero; done flags the last cycle of a wait.
module lcd_delay_counter #(
    parameter int               WIDTH   = 20,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic             done
);

    logic [WIDTH-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= RST_VAL;
        end else if (load) begin
            count <= load_val;
        end else if (count != '0) begin
            count <= count - WIDTH'(1);
        end
    end

    assign done = (count == '0);

endmodule : lcd_delay_counter
`default_nettype wire

// File: rtl/lcd_nibble_writer.sv
`default_nettype none
// lcd_nibble_writer: byte-to-nibble HD44780 4-bit transmitter with RS/E/DB timing.
// Define LCD_INIT_SEQ_EN to run the power-on init sequence on chip before accepting bytes.
module lcd_nibble_writer
    import lcd_pkg::*;
#(
    parameter int SETUP_CYC        = DEF_SETUP_CYC,
    parameter int E_HIGH_CYC       = DEF_E_HIGH_CYC,
    parameter int NIB_GAP_CYC      = DEF_NIB_GAP_CYC,
    parameter int CHAR_WAIT_CYC    = DEF_CHAR_WAIT_CYC,
    parameter int CLEAR_WAIT_CYC   = DEF_CLEAR_WAIT_CYC,
    parameter int POWERON_WAIT_CYC = DEF_POWERON_WAIT_CYC
) (
    input  logic       qzt_clk,
    input  logic       reset,
    input  logic       in_valid,
    input  logic       in_rs,
    input  logic [7:0] in_byte,
    output logic       in_ready,
    output logic       lcd_rs,
    output logic       lcd_e,
    output logic [3:0] lcd_data,
    output logic       init_done
);

`ifdef LCD_INIT_SEQ_EN
    localparam logic [CNT_W-1:0] BOOT_VAL = CNT_W'(POWERON_WAIT_CYC - 1);
`else
    // Two edges after release: count 1 -> 0, then leave RESET_WAIT
    localparam logic [CNT_W-1:0] BOOT_VAL = CNT_W'(1);
`endif

    state_t     state;
    logic [3:0] lo_nib;
    logic       lo_phase;
    logic       single_nib;
    wait_sel_t  wait_sel_q;

    logic             accept;
    logic             cnt_load;
    logic [CNT_W-1:0] cnt_val;
    logic             cnt_done;

`ifdef LCD_INIT_SEQ_EN
    logic [2:0]  step;
    init_entry_t rom_entry;
    assign rom_entry = init_rom(step);
`endif

    assign accept = in_valid && in_ready;

    function automatic logic [CNT_W-1:0] wait_len(input wait_sel_t sel);
        case (sel)
            WAIT_CLEAR: wait_len = CNT_W'(CLEAR_WAIT_CYC - 1);
            WAIT_LONG:  wait_len = CNT_W'(INIT_WAIT_LONG_CYC - 1);
            WAIT_SHORT: wait_len = CNT_W'(INIT_WAIT_SHORT_CYC - 1);
            default:    wait_len = CNT_W'(CHAR_WAIT_CYC - 1);
        endcase
    endfunction

    // Counter is reloaded with (length-1) of the state being entered on every transition
    always_comb begin
        cnt_load = 1'b0;
        cnt_val  = '0;
        case (state)
            IDLE: begin
                cnt_load = accept;
                cnt_val  = CNT_W'(SETUP_CYC - 1);
            end
            SETUP: begin
                cnt_load = cnt_done;
                cnt_val  = CNT_W'(E_HIGH_CYC - 1);
            end
            PULSE: begin
                cnt_load = cnt_done;
                cnt_val  = CNT_W'(NIB_GAP_CYC - 1);
            end
            GAP: begin
                cnt_load = cnt_done;
                cnt_val  = (!lo_phase && !single_nib) ? CNT_W'(SETUP_CYC - 1) : wait_len(wait_sel_q);
            end
`ifdef LCD_INIT_SEQ_EN
            INIT_NIB: begin
                cnt_load = 1'b1;
                cnt_val  = CNT_W'(SETUP_CYC - 1);
            end
`endif
            default: begin
                cnt_load = cnt_done;
                cnt_val  = '0;
            end
        endcase
    end

    lcd_delay_counter #(
        .WIDTH   (CNT_W),
        .RST_VAL (BOOT_VAL)
    ) u_delay (
        .clk      (qzt_clk),
        .rst_n    (reset),
        .load     (cnt_load),
        .load_val (cnt_val),
        .done     (cnt_done)
    );

    always_ff @(posedge qzt_clk or negedge reset) begin
        if (!reset) begin
            state      <= RESET_WAIT;
            lcd_e      <= 1'b0;
            lcd_rs     <= 1'b0;
            lcd_data   <= 4'h0;
            in_ready   <= 1'b0;
            init_done  <= 1'b0;
            lo_nib     <= 4'h0;
            lo_phase   <= 1'b0;
            single_nib <= 1'b0;
            wait_sel_q <= WAIT_CHAR;
`ifdef LCD_INIT_SEQ_EN
            step       <= 3'd0;
`endif
        end else begin
            case (state)
                RESET_WAIT: begin
                    if (cnt_done) begin
`ifdef LCD_INIT_SEQ_EN
                        state     <= INIT_NIB;
`else
                        state     <= IDLE;
                        init_done <= 1'b1;
                        in_ready  <= 1'b1;
`endif
                    end
                end
                IDLE: begin
                    if (accept) begin
                        lcd_rs     <= in_rs;
                        lcd_data   <= in_byte[7:4];
                        lo_nib     <= in_byte[3:0];
                        lo_phase   <= 1'b0;
                        single_nib <= 1'b0;
                        wait_sel_q <= byte_wait_sel(in_rs, in_byte);
                        in_ready   <= 1'b0;
                        state      <= SETUP;
                    end
                end
                SETUP: begin
                    if (cnt_done) begin
                        lcd_e <= 1'b1;
                        state <= PULSE;
                    end
                end
                PULSE: begin
                    if (cnt_done) begin
                        lcd_e <= 1'b0;
                        state <= GAP;
                    end
                end
                GAP: begin
                    if (cnt_done) begin
                        if (!lo_phase && !single_nib) begin
                            lo_phase <= 1'b1;
                            lcd_data <= lo_nib;
                            state    <= SETUP;
                        end else begin
`ifdef LCD_INIT_SEQ_EN
                            state <= init_done ? EXEC_WAIT : INIT_WAIT;
`else
                            state <= EXEC_WAIT;
`endif
                        end
                    end
                end
                EXEC_WAIT: begin
                    if (cnt_done) begin
                        in_ready <= 1'b1;
                        state    <= IDLE;
                    end
                end
`ifdef LCD_INIT_SEQ_EN
                INIT_WAIT: begin
                    if (cnt_done) begin
                        if (step == 3'd7) begin
                            init_done <= 1'b1;
                            in_ready  <= 1'b1;
                            state     <= IDLE;
                        end else begin
                            step  <= step + 3'd1;
                            state <= INIT_NIB;
                        end
                    end
                end
                INIT_NIB: begin
                    lcd_rs     <= 1'b0;
                    lcd_data   <= rom_entry.cmd[7:4];
                    lo_nib     <= rom_entry.cmd[3:0];
                    lo_phase   <= 1'b0;
                    single_nib <= rom_entry.is_nibble;
                    wait_sel_q <= rom_entry.wait_sel;
                    state      <= SETUP;
                end
`endif
                default: begin
                    state <= RESET_WAIT;
                end
            endcase
        end
    end

endmodule : lcd_nibble_writer
`default_nettype wire
